vproc_mul_seq32: RTL and testbench
==================================

Name: vproc_mul_seq32

Overview:
Iterative 32x32 multiply sequencer that sits directly upstream and downstream of the 17x17 multiply block. It splits 32-bit operands into 16-bit halves and issues one partial product per cycle to the multiply block. It accumulates the returned 33-bit partial products into a 64-bit sum and returns the low or high 32 bits. It covers vmul, vmulh, vmulhu and vmulhsu for one element lane.

Parameters:
MUL_LAT, 0, multiply block pipeline depth in cycles (number of enabled BUF_OPS/BUF_MUL/BUF_RES stages, legal 0..3)
TAG_W, 4, width of opaque tag carried from request to result

Ports:
clk_i  in  1  clock
async_rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  request valid
in_ready_o  out  1  request accepted when valid&ready
op1_i  in  32  multiplicand
op2_i  in  32  multiplier
op1_signed_i  in  1  treat op1 as signed
op2_signed_i  in  1  treat op2 as signed
hi_sel_i  in  1  1: return product[63:32]; 0: return product[31:0]
tag_i  in  TAG_W  request tag
mul_op1_o  out  17  operand chunk to multiply block
mul_op2_o  out  17  operand chunk to multiply block
mul_acc_o  out  16  tied 0
mul_acc_flag_o  out  1  tied 0 (accumulation is done locally)
mul_acc_sub_o  out  1  tied 0
mul_ready_o  out  1  multiply block stage enable, constant 1 out of reset
mul_res_i  in  33  signed partial product from multiply block, MUL_LAT cycles after issue
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed when valid&ready
res_o  out  32  selected result half
res_tag_o  out  TAG_W  tag of result

Behaviour:
- Reset (async, active-low): state IDLE; res_valid_o=0; res_o=0; res_tag_o=0; mul_op1_o/mul_op2_o=0; accumulator=0; issue/delay-line valids=0. mul_ready_o=1 when not in reset.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready_o=1. On accept, register the operands, sign flags, hi_sel and tag, clear the accumulator, and go to ISSUE.
- Chunk encoding: low halves are zero-extended to 17 bits. High halves are sign-extended if the corresponding signed flag is set, else zero-extended.
- Issue order: LL (shift 0), LH (16), HL (16), HH (32). With hi_sel=0, HH is skipped, so N=3; otherwise N=4.
- ISSUE: one chunk pair per cycle, counter 0..N-1. Outside valid issue cycles, chunks are driven to 0.
- A delay line of MUL_LAT stages carries {valid, shift code} alongside each issue, so a result is matched to its shift when it arrives.
- When a valid result arrives: acc <= acc + (sext64(mul_res_i) << shift), arithmetic modulo 2^64.
- After the last issue, go to DRAIN if MUL_LAT>0, otherwise to DONE. DRAIN exits to DONE when the delay line is empty.
- Timing for an accept in cycle T:
  - issues occur in cycles T+1..T+N;
  - res_valid_o rises in cycle T+N+MUL_LAT+1;
  - with hi_sel=1 and MUL_LAT=0, that is T+5.
- DONE: res_o = hi_sel ? acc[63:32] : acc[31:0]; res_tag_o = stored tag. Outputs are held stable while res_ready_i=0.
- DONE with res_ready_i=1: res_valid_o drops next cycle. in_ready_o=1 in the same cycle, so a back-to-back accept goes straight to ISSUE without an IDLE bubble.
- in_ready_o=0 in ISSUE and DRAIN. in_valid_i is ignored there and no request is lost (the upstream source holds it).
- Input changes on op*_i after accept have no effect.
- Reset mid-operation abandons the computation. The delay line is cleared, so late mul_res_i values are ignored.

Decomposition:
- vproc_pkg additions:
  - mul_seq_state_e enum: IDLE, ISSUE, DRAIN, DONE.
  - 2-bit partial-product shift code type: 0, 16, 32.
- Sub-module: vproc_mul_seq_dline, the MUL_LAT-deep {valid, shift} delay line. It must degenerate to a wire at MUL_LAT=0.
- The bench instantiates vproc_mul_block (MUL_GENERIC) with matching BUF_* settings.

Test Plan:
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF, hi_sel=1, MUL_LAT=0 -> res_o=0xFFFFFFFE at cycle T+5. Repeat with hi_sel=0 -> res_o=0x00000001 at cycle T+4.
- Signed x signed 0x80000000 x 0x80000000, hi_sel=1 -> 0x40000000. Signed x signed 0xFFFFFFFF x 0xFFFFFFFF -> hi 0x00000000, lo 0x00000001.
- vmulhsu: op1=0xFFFFFFFF signed, op2=0xFFFFFFFF unsigned, hi_sel=1 -> 0xFFFFFFFF. Same operands with hi_sel=0 -> 0x00000001.
- Sweep MUL_LAT 0..3 with random operands against a 64-bit reference model. The latency check N+MUL_LAT+1 must hold, and tags must match in order.
- Hold res_ready_i low 5 cycles with a second request pending -> res_o and res_tag_o stable, in_ready_o=0. On release, back-to-back accept occurs in the same cycle and the second result is correct.
- Assert reset during ISSUE with MUL_LAT=2 -> all outputs return to reset values. The next request yields a correct result, unaffected by stale mul_res_i.

Source files
------------

// File: rtl/vproc_mul_seq32_pkg.sv
// Shared types for the iterative 32x32 multiply sequencer.
package vproc_mul_seq32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mul_seq_state_e;

  // Left shift applied to a partial product before accumulation.
  typedef enum logic [1:0] {
    SH_0  = 2'd0,
    SH_16 = 2'd1,
    SH_32 = 2'd2
  } mul_shift_e;

  // Sign-extend a 33-bit partial product to 64 bits and align it.
  function automatic logic [63:0] shift_pp(input logic [32:0] pp, input mul_shift_e sh);
    logic [63:0] x;
    logic [63:0] r;
    x = {{31{pp[32]}}, pp};
    unique case (sh)
      SH_16:   r = x << 16;
      SH_32:   r = x << 32;
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vproc_mul_seq_dline.sv
// Delay line carrying {valid, shift} alongside each partial product in
// flight through the multiply block. Degenerates to wires at LAT=0.
module vproc_mul_seq_dline
  import vproc_mul_seq32_pkg::*;
#(
  parameter int unsigned LAT = 0
) (
  input  logic       clk_i,
  input  logic       async_rst_ni,
  input  logic       valid_i,
  input  mul_shift_e shift_i,
  output logic       valid_o,
  output mul_shift_e shift_o,
  output logic       inflight_o
);

  if (LAT == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ async_rst_ni;
    assign valid_o        = valid_i;
    assign shift_o        = shift_i;
    assign inflight_o     = 1'b0;
  end else begin : g_pipe
    logic [LAT-1:0] vld_q, vld_d;
    mul_shift_e     sh_q [LAT];
    mul_shift_e     sh_d [LAT];

    // Advance every stage by one slot per cycle
    always_comb begin
      vld_d[0] = valid_i;
      sh_d[0]  = shift_i;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        sh_d[i]  = sh_q[i-1];
      end
    end

    // Stage registers; reset drops anything still in flight
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
        vld_q <= '0;
        for (int unsigned i = 0; i < LAT; i++) sh_q[i] <= SH_0;
      end else begin
        vld_q <= vld_d;
        for (int unsigned i = 0; i < LAT; i++) sh_q[i] <= sh_d[i];
      end
    end

    assign valid_o = vld_q[LAT-1];
    assign shift_o = sh_q[LAT-1];

    // Entries ahead of the output stage will still be in flight next cycle
    always_comb begin
      inflight_o = 1'b0;
      for (int unsigned i = 0; i + 1 < LAT; i++) inflight_o = inflight_o | vld_q[i];
    end
  end

endmodule

// File: rtl/vproc_mul_seq32.sv
// Iterative 32x32 multiply sequencer: issues 16-bit chunk products to a
// 17x17 multiply block and accumulates the partial products locally.
module vproc_mul_seq32
  import vproc_mul_seq32_pkg::*;
#(
  parameter int unsigned MUL_LAT = 0,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             async_rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      op1_i,
  input  logic [31:0]      op2_i,
  input  logic             op1_signed_i,
  input  logic             op2_signed_i,
  input  logic             hi_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [16:0]      mul_op1_o,
  output logic [16:0]      mul_op2_o,
  output logic [15:0]      mul_acc_o,
  output logic             mul_acc_flag_o,
  output logic             mul_acc_sub_o,
  output logic             mul_ready_o,
  input  logic [32:0]      mul_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_o,
  output logic [TAG_W-1:0] res_tag_o
);

  mul_seq_state_e   state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d;
  logic             sgn1_q, sgn1_d, sgn2_q, sgn2_d, hi_q, hi_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      acc_q, acc_d;

  logic             issue_vld, last_issue, ready;
  logic [16:0]      chunk1, chunk2, lo1, hi1, lo2, hi2;
  mul_shift_e       issue_sh, res_sh;
  logic             res_vld, inflight;

  // Pick the operand halves for the current issue slot (LL, LH, HL, HH)
  always_comb begin
    lo1        = {1'b0, op1_q[15:0]};
    lo2        = {1'b0, op2_q[15:0]};
    hi1        = {sgn1_q & op1_q[31], op1_q[31:16]};
    hi2        = {sgn2_q & op2_q[31], op2_q[31:16]};
    issue_vld  = (state_q == ISSUE);
    last_issue = (cnt_q == (hi_q ? 2'd3 : 2'd2));
    unique case (cnt_q)
      2'd0:    begin chunk1 = lo1; chunk2 = lo2; issue_sh = SH_0;  end
      2'd1:    begin chunk1 = lo1; chunk2 = hi2; issue_sh = SH_16; end
      2'd2:    begin chunk1 = hi1; chunk2 = lo2; issue_sh = SH_16; end
      default: begin chunk1 = hi1; chunk2 = hi2; issue_sh = SH_32; end
    endcase
  end

  assign mul_op1_o      = issue_vld ? chunk1 : '0;
  assign mul_op2_o      = issue_vld ? chunk2 : '0;
  assign mul_acc_o      = '0;
  assign mul_acc_flag_o = 1'b0;
  assign mul_acc_sub_o  = 1'b0;
  assign mul_ready_o    = async_rst_ni;

  vproc_mul_seq_dline #(
    .LAT (MUL_LAT)
  ) u_dline (
    .clk_i        (clk_i),
    .async_rst_ni (async_rst_ni),
    .valid_i      (issue_vld),
    .shift_i      (issue_sh),
    .valid_o      (res_vld),
    .shift_o      (res_sh),
    .inflight_o   (inflight)
  );

  // Sequencer control and accumulation; DONE+consume re-accepts directly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sgn1_d  = sgn1_q;
    sgn2_d  = sgn2_q;
    hi_d    = hi_q;
    tag_d   = tag_q;
    acc_d   = acc_q;
    ready   = 1'b0;
    if (res_vld) acc_d = acc_q + shift_pp(mul_res_i, res_sh);
    unique case (state_q)
      IDLE:  ready = 1'b1;
      ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (last_issue) state_d = (MUL_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: if (!inflight) state_d = DONE;
      default: if (res_ready_i) begin
        ready   = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (ready && in_valid_i) begin
      op1_d   = op1_i;
      op2_d   = op2_i;
      sgn1_d  = op1_signed_i;
      sgn2_d  = op2_signed_i;
      hi_d    = hi_sel_i;
      tag_d   = tag_i;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ISSUE;
    end
  end

  assign in_ready_o  = ready;
  assign res_valid_o = (state_q == DONE);
  assign res_o       = (state_q == DONE) ? (hi_q ? acc_q[63:32] : acc_q[31:0]) : '0;
  assign res_tag_o   = (state_q == DONE) ? tag_q : '0;

  // Sequencer state registers
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sgn1_q  <= 1'b0;
      sgn2_q  <= 1'b0;
      hi_q    <= 1'b0;
      tag_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sgn1_q  <= sgn1_d;
      sgn2_q  <= sgn2_d;
      hi_q    <= hi_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_vproc_mul_seq32.sv
// Bench: four sequencers (MUL_LAT 0..3) share one request stream, each
// paired with a behavioural 17x17 signed multiply pipeline of matching depth.
module tb_vproc_mul_seq32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] op1, op2;
  logic        s1, s2, hi;
  logic [3:0]  tag;
  logic        res_ready;

  logic [3:0]  rv, ir, mrdy, tied;
  logic [31:0] ro  [4];
  logic [3:0]  rt  [4];
  logic [16:0] mo1 [4];
  logic [16:0] mo2 [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [16:0]        m1, m2;
    logic [32:0]        mres;
    logic signed [33:0] p34;
    logic [32:0]        pipe [3];
    logic [15:0]        macc;
    logic               mflag, msub, mr, v, irdy;
    logic [31:0]        r;
    logic [3:0]         t;

    vproc_mul_seq32 #(.MUL_LAT(g), .TAG_W(4)) u_dut (
      .clk_i          (clk),
      .async_rst_ni   (rst_n),
      .in_valid_i     (in_valid),
      .in_ready_o     (irdy),
      .op1_i          (op1),
      .op2_i          (op2),
      .op1_signed_i   (s1),
      .op2_signed_i   (s2),
      .hi_sel_i       (hi),
      .tag_i          (tag),
      .mul_op1_o      (m1),
      .mul_op2_o      (m2),
      .mul_acc_o      (macc),
      .mul_acc_flag_o (mflag),
      .mul_acc_sub_o  (msub),
      .mul_ready_o    (mr),
      .mul_res_i      (mres),
      .res_valid_o    (v),
      .res_ready_i    (res_ready),
      .res_o          (r),
      .res_tag_o      (t)
    );

    // Multiply block model: not reset, so stale products keep flowing
    assign p34 = $signed(m1) * $signed(m2);
    always @(posedge clk) begin
      pipe[0] <= p34[32:0];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    if (g == 0) begin : g_comb
      assign mres = p34[32:0];
    end else begin : g_reg
      assign mres = pipe[g-1];
    end

    assign rv[g]   = v;
    assign ir[g]   = irdy;
    assign mrdy[g] = mr;
    assign tied[g] = (macc != 16'h0) | mflag | msub;
    assign ro[g]   = r;
    assign rt[g]   = t;
    assign mo1[g]  = m1;
    assign mo2[g]  = m2;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Full-width reference product, then pick the requested half
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb, input logic h);
    logic [63:0] xa, xb, p;
    xa = sa ? {{32{a[31]}}, a} : {32'h0, a};
    xb = sb ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    return h ? p[63:32] : p[31:0];
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, input logic h, input logic [3:0] tg);
    in_valid = 1'b1;
    op1 = a; op2 = b; s1 = sa; s2 = sb; hi = h; tag = tg;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom;
    s1 = 1'($urandom); s2 = 1'($urandom); hi = 1'($urandom); tag = 4'($urandom);
  endtask

  // Called in cycle T+1 after an accept in cycle T (res_ready held high)
  task automatic track(input logic h, input logic [31:0] exp_r, input logic [3:0] exp_t);
    int n;
    logic ev;
    n = h ? 4 : 3;
    for (int k = 1; k <= n + 5; k++) begin
      for (int g = 0; g < 4; g++) begin
        ev = (k == n + g + 1);
        chk($sformatf("res_valid L%0d k%0d", g, k), rv[g], ev);
        if (ev) begin
          chk($sformatf("res_o L%0d", g), ro[g], exp_r);
          chk($sformatf("res_tag_o L%0d", g), rt[g], exp_t);
        end
        if (k > n) begin
          chk($sformatf("mul_op1 idle L%0d", g), mo1[g], 0);
          chk($sformatf("mul_op2 idle L%0d", g), mo2[g], 0);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic sa,
                        input logic sb, input logic h, input logic [31:0] exp_r);
    logic [3:0] tg;
    tg = 4'($urandom);
    @(negedge clk);
    chk("in_ready idle", ir, 4'hF);
    drive(a, b, sa, sb, h, tg);
    @(negedge clk);
    scramble();
    track(h, exp_r, tg);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sa, sb, h;
    logic [31:0] exp;
  } vec_t;

  vec_t dir [8];

  initial begin
    logic [31:0] a, b, ea, eb;
    logic        sa, sb, h;
    logic [3:0]  ta, tb;

    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    op1 = '0; op2 = '0; s1 = 1'b0; s2 = 1'b0; hi = 1'b0; tag = '0;
    repeat (2) @(negedge clk);
    chk("reset res_valid", rv, 4'h0);
    chk("reset mul_ready", mrdy, 4'h0);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset res_o L%0d", g), ro[g], 0);
      chk($sformatf("reset res_tag_o L%0d", g), rt[g], 0);
      chk($sformatf("reset mul_op1 L%0d", g), mo1[g], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mul_ready out of reset", mrdy, 4'hF);
    chk("acc ports tied", tied, 4'h0);

    // Directed corner products
    dir[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
    dir[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
    dir[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
    dir[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000};
    dir[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h00000001};
    dir[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    dir[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
    dir[7] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 32'hC0000000};
    for (int i = 0; i < 8; i++)
      do_req(dir[i].a, dir[i].b, dir[i].sa, dir[i].sb, dir[i].h, dir[i].exp);

    // Random operands against the 64-bit reference
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      sa = 1'($urandom); sb = 1'($urandom); h = 1'($urandom);
      do_req(a, b, sa, sb, h, ref_mul(a, b, sa, sb, h));
    end

    // Back-pressure with a second request waiting
    a = $urandom; b = $urandom; ta = 4'hA;
    ea = ref_mul(a, b, 1'b1, 1'b0, 1'b1);
    eb = $urandom; tb = 4'h5;
    res_ready = 1'b0;
    @(negedge clk);
    drive(a, b, 1'b1, 1'b0, 1'b1, ta);
    @(negedge clk);
    scramble();
    for (int i = 0; i < 12 && rv != 4'hF; i++) @(negedge clk);
    chk("bp all valid", rv, 4'hF);
    drive(eb, 32'h12345679, 1'b0, 1'b1, 1'b0, tb);
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready held", ir, 4'h0);
      chk("bp res_valid held", rv, 4'hF);
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("bp res_o L%0d", g), ro[g], ea);
        chk($sformatf("bp res_tag_o L%0d", g), rt[g], ta);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("bp release in_ready", ir, 4'hF);
    @(negedge clk);
    scramble();
    track(1'b0, ref_mul(eb, 32'h12345679, 1'b0, 1'b1, 1'b0), tb);

    // Reset pulse while the sequencers are issuing
    @(negedge clk);
    drive(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 4'h7);
    @(negedge clk);
    scramble();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset res_valid", rv, 4'h0);
    chk("midreset in_ready", ir, 4'hF);
    chk("midreset mul_ready", mrdy, 4'h0);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("midreset res_o L%0d", g), ro[g], 0);
      chk($sformatf("midreset res_tag_o L%0d", g), rt[g], 0);
      chk($sformatf("midreset mul_op1 L%0d", g), mo1[g], 0);
      chk($sformatf("midreset mul_op2 L%0d", g), mo2[g], 0);
    end
    #1;
    rst_n = 1'b1;
    a = 32'h0001_0003; b = 32'h0002_0005;
    do_req(a, b, 1'b0, 1'b0, 1'b0, ref_mul(a, b, 1'b0, 1'b0, 1'b0));
    a = $urandom; b = $urandom;
    do_req(a, b, 1'b1, 1'b1, 1'b1, ref_mul(a, b, 1'b1, 1'b1, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
